// File: rtl/bootrom_pkg.sv
// Shared definitions for the bootrom front-ends: FSM states and the ROM address map.
package bootrom_pkg;

    localparam int          RomAddrBits = 11;
    localparam int          RomBytes    = 1024;
    localparam logic [63:0] BaseAddr    = 64'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        RSP   = 2'd3
    } state_e;

endpackage

// File: rtl/bootrom_range_check.sv
// Combinational offset computation and error decode for a bootrom request.
// Also used by the debug-ROM front-end.
module bootrom_range_check #(
    parameter int                   AddrWidth   = 48,
    parameter int                   RomAddrBits = 11,
    parameter int                   RomBytes    = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0
) (
    input  logic [AddrWidth-1:0]   addr,
    input  logic                   we,
    output logic [RomAddrBits-1:0] word_addr,
    output logic                   error
);

    localparam logic [AddrWidth-1:0] RomLimit = AddrWidth'(RomBytes);

    logic [AddrWidth-1:0] off;
    logic                 borrow;

    // A borrow out of the subtraction means the address lies below the ROM base.
    always_comb begin
        {borrow, off} = {1'b0, addr} - {1'b0, BaseAddr};
        word_addr     = off[RomAddrBits+1:2];
        error         = we | borrow | (off >= RomLimit);
    end

endmodule

// File: rtl/bootrom_req_adapter.sv
// Valid/ready front-end for the combinational bootrom. A 64-bit response is built
// from two registered 32-bit ROM lookups. Only one request is in flight at a time.
module bootrom_req_adapter #(
    parameter int                   AddrWidth   = 48,
    parameter int                   BusWidth    = 64,
    parameter int                   RomAddrBits = bootrom_pkg::RomAddrBits,
    parameter int                   RomBytes    = bootrom_pkg::RomBytes,
    parameter logic [AddrWidth-1:0] BaseAddr    = AddrWidth'(bootrom_pkg::BaseAddr)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_we_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [BusWidth-1:0]    rsp_rdata_o,
    output logic                   rsp_error_o,
    output logic [RomAddrBits-1:0] rom_addr_o,
    input  logic [31:0]            rom_data_i,
    output logic [1:0]             dbg_state_o
);

    import bootrom_pkg::*;

    localparam bit Wide = (BusWidth == 64);

    // Handshakes: a request transfers on a clock edge where req_valid_i and req_ready_o
    // are both high; a response transfers where rsp_valid_o and rsp_ready_i are both
    // high. Both ready and valid are decoded from the registered state only.

    state_e                 state_q, state_d;
    logic [63:0]            rdata_q;
    logic                   error_q;
    logic [RomAddrBits-1:0] rom_addr_q;
    logic [RomAddrBits-1:0] word_addr;
    logic                   range_err;

    bootrom_range_check #(
        .AddrWidth  (AddrWidth),
        .RomAddrBits(RomAddrBits),
        .RomBytes   (RomBytes),
        .BaseAddr   (BaseAddr)
    ) u_range_check (
        .addr     (req_addr_i),
        .we       (req_we_i),
        .word_addr(word_addr),
        .error    (range_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = range_err ? RSP : RD_LO;
                end
            end
            RD_LO:   state_d = Wide ? RD_HI : RSP;
            RD_HI:   state_d = RSP;
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ROM data is captured at the end of a cycle whose address was registered at its start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q    <= '0;
            error_q    <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (range_err) begin
                            error_q <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            rom_addr_q <= Wide ? {word_addr[RomAddrBits-1:1], 1'b0} : word_addr;
                        end
                    end
                end
                RD_LO: begin
                    rdata_q[31:0] <= rom_data_i;
                    if (Wide) begin
                        rom_addr_q[0] <= 1'b1;
                    end
                end
                RD_HI: rdata_q[63:32] <= rom_data_i;
                RSP: begin
                    if (rsp_ready_i) begin
                        rdata_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata_o = rdata_q[BusWidth-1:0];
    assign rsp_error_o = error_q;
    assign rom_addr_o  = rom_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bootrom_req_adapter.sv
// Bench for bootrom_req_adapter: a 64-bit and a 32-bit instance, each fed by a ROM model
// that returns 0xA5000000 | word_index.
module tb_bootrom_req_adapter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        req_valid, req_ready, req_we;
    logic [47:0] req_addr;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [63:0] rsp_rdata;
    logic [10:0] rom_addr;
    logic [31:0] rom_data;
    logic [1:0]  dbg_state;

    // 32-bit instance
    logic        s32_req_valid, s32_req_ready, s32_req_we;
    logic [47:0] s32_req_addr;
    logic        s32_rsp_valid, s32_rsp_ready, s32_rsp_error;
    logic [31:0] s32_rsp_rdata;
    logic [10:0] s32_rom_addr;
    logic [31:0] s32_rom_data;
    logic [1:0]  s32_dbg_state;

    assign rom_data     = 32'hA500_0000 | {21'b0, rom_addr};
    assign s32_rom_data = 32'hA500_0000 | {21'b0, s32_rom_addr};

    bootrom_req_adapter #(.BusWidth(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_we_i(req_we),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .dbg_state_o(dbg_state)
    );

    bootrom_req_adapter #(.BusWidth(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(s32_req_valid), .req_ready_o(s32_req_ready),
        .req_addr_i(s32_req_addr), .req_we_i(s32_req_we),
        .rsp_valid_o(s32_rsp_valid), .rsp_ready_i(s32_rsp_ready),
        .rsp_rdata_o(s32_rsp_rdata), .rsp_error_o(s32_rsp_error),
        .rom_addr_o(s32_rom_addr), .rom_data_i(s32_rom_data),
        .dbg_state_o(s32_dbg_state)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic        exp_err_q[$];
    logic [31:0] exp32_q[$];
    logic        exp32_err_q[$];

    logic [63:0] mon_d;
    logic        mon_e;

    // Scoreboard for the 64-bit instance: pop on every response handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h error %b with nothing outstanding", rsp_rdata, rsp_error);
            end else begin
                mon_d = exp_q.pop_front();
                mon_e = exp_err_q.pop_front();
                checks++;
                if (rsp_rdata !== mon_d) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, mon_d);
                end
                checks++;
                if (rsp_error !== mon_e) begin
                    errors++;
                    $display("FAIL rsp_error: got %b want %b", rsp_error, mon_e);
                end
            end
        end
    end

    function automatic void model64(input logic [47:0] addr, input logic we,
                                    output logic [63:0] d, output logic e, output int lat);
        logic [10:0] w;
        w = {addr[12:3], 1'b0};
        if (we || addr >= 48'd1024) begin
            d = '0; e = 1'b1; lat = 1;
        end else begin
            d = {32'hA500_0000 | {21'b0, w | 11'd1}, 32'hA500_0000 | {21'b0, w}};
            e = 1'b0; lat = 3;
        end
    endfunction

    task automatic issue64(input logic [47:0] addr, input logic we, input string name);
        logic [63:0] d;
        logic        e;
        int          lat;
        int          n;
        logic [10:0] a0, w;
        logic [10:0] seq[4];
        model64(addr, we, d, e, lat);
        w = {addr[12:3], 1'b0};
        exp_q.push_back(d);
        exp_err_q.push_back(e);
        @(negedge clk);
        a0 = rom_addr;
        req_valid = 1'b1; req_addr = addr; req_we = we;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready %b want 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 'x;
        seq[0] = rom_addr;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n <= 4) seq[n-1] = rom_addr;
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        if (e) begin
            checks++;
            if (seq[0] !== a0) begin
                errors++;
                $display("FAIL %s rom_addr_hold: got %h want %h", name, seq[0], a0);
            end
        end else begin
            checks++;
            if (seq[0] !== w || seq[1] !== (w | 11'd1)) begin
                errors++;
                $display("FAIL %s rom_addr_seq: got %h,%h want %h,%h", name, seq[0], seq[1], w, w | 11'd1);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL %s after_hs: valid %b rdata %h error %b want 0,0,0", name, rsp_valid, rsp_rdata, rsp_error);
        end
    endtask

    task automatic issue32(input logic [47:0] addr, input logic we, input string name);
        logic [31:0] d, gd;
        logic        e, ge;
        int          lat;
        int          n;
        if (we || addr >= 48'd1024) begin
            d = '0; e = 1'b1; lat = 1;
        end else begin
            d = 32'hA500_0000 | {21'b0, addr[12:2]}; e = 1'b0; lat = 2;
        end
        exp32_q.push_back(d);
        exp32_err_q.push_back(e);
        @(negedge clk);
        s32_req_valid = 1'b1; s32_req_addr = addr; s32_req_we = we;
        n = 0;
        while (!s32_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s32_req_valid = 1'b0; s32_req_we = 1'b0;
        n = 1;
        while (!s32_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        gd = exp32_q.pop_front();
        ge = exp32_err_q.pop_front();
        checks++;
        if (s32_rsp_rdata !== gd || s32_rsp_error !== ge) begin
            errors++;
            $display("FAIL %s rsp: got %h/%b want %h/%b", name, s32_rsp_rdata, s32_rsp_error, gd, ge);
        end
        s32_rsp_ready = 1'b1;
        @(posedge clk); #1;
        s32_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; rsp_ready = 1'b0;
        s32_req_valid = 1'b0; s32_req_addr = '0; s32_req_we = 1'b0; s32_rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++;
        if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", rsp_error); end
        checks++;
        if (rom_addr !== 11'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read64();
        issue64(48'h000, 1'b0, "rd_0x000");
        issue64(48'h3F8, 1'b0, "rd_last_pair");
        issue64(48'h3FC, 1'b0, "rd_bit2_ignored");
        issue64(48'h400, 1'b0, "rd_0x400_oor");
        issue64(48'hFFFF_0000_0000, 1'b0, "rd_high_oor");
    endtask

    task automatic test_write_error();
        issue64(48'h010, 1'b1, "wr_0x010");
        issue64(48'h010, 1'b0, "rd_0x010");
        issue64(48'h013, 1'b0, "rd_0x013_low_bits");
    endtask

    task automatic test_back_to_back();
        logic [63:0] da, db;
        logic        ea, eb;
        int          la, lb, n;
        model64(48'h080, 1'b0, da, ea, la);
        model64(48'h100, 1'b0, db, eb, lb);
        exp_q.push_back(da); exp_err_q.push_back(ea);
        exp_q.push_back(db); exp_err_q.push_back(eb);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 48'h080; req_we = 1'b0;
        @(posedge clk); #1;
        req_addr = 48'h100;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== da || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid %b rdata %h ready %b want 1 %h 0", i, rsp_valid, rsp_rdata, req_ready, da);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL bp_next_accept: ready %b state %0d want 0 1", req_ready, dbg_state);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 48'h040; req_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_state: got %0d want 2", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rom_addr !== 11'h0 || rsp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: valid %b ready %b rom %h rdata %h", rsp_valid, req_ready, rom_addr, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale: got stale activity %b want 0", seen); end
    endtask

    task automatic test_read32();
        issue32(48'h00C, 1'b0, "rd32_0x00C");
        issue32(48'h3FC, 1'b0, "rd32_last_word");
        issue32(48'h400, 1'b0, "rd32_oor");
        issue32(48'h020, 1'b1, "wr32");
    endtask

    task automatic test_random();
        logic [47:0] a;
        logic        w;
        for (int i = 0; i < 8; i++) begin
            a = 48'($urandom_range(0, 'h47F));
            w = ($urandom_range(0, 3) == 0);
            issue64(a, w, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_read64();
        test_write_error();
        test_back_to_back();
        test_reset_mid();
        test_read32();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
